// File: rtl/usart_pkg.sv
// Shared USART receive definitions: frame FSM state encoding, parity mode codes,
// minimum character size and the character-size clamp helper.
package usart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    PAR   = 3'd2,
    STOP1 = 3'd3,
    STOP2 = 3'd4,
    DONE  = 3'd5
  } rx_state_t;

  localparam logic [1:0] UPM_NONE = 2'b00;
  localparam logic [1:0] UPM_RSVD = 2'b01;
  localparam logic [1:0] UPM_EVEN = 2'b10;
  localparam logic [1:0] UPM_ODD  = 2'b11;

  localparam int CHSZ_MIN = 5;

  // Any size outside CHSZ_MIN..max_c falls back to the widest supported character.
  function automatic logic [3:0] chsz_clamp(input logic [3:0] c, input logic [3:0] max_c);
    return (c < 4'(CHSZ_MIN) || c > max_c) ? max_c : c;
  endfunction

endpackage

// File: rtl/usart_rx_frame.sv
// USART receive frame engine: start, 5..DATA_MAX data bits LSB-first, optional parity, 1/2 stops,
// with a one-entry holding buffer. Parity support is built only when USART_RX_PARITY_EN is defined.
module usart_rx_frame
  import usart_pkg::*;
#(
  parameter int DATA_MAX = 9,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                rxd,
  input  logic [3:0]          chsz,
  input  logic [1:0]          upm,
  input  logic                sbs,
  input  logic                rx_ack,
  output logic [DATA_MAX-1:0] data_o,
  output logic                rx_valid,
  output logic                fe,
  output logic                pe,
  output logic                dor,
  output logic                busy
);

  rx_state_t state, state_nxt;

  logic                start, shift_en, par_smp, stop_smp, done;
  logic [CNT_W-1:0]    cnt, chsz_q, shamt;
  logic                sbs_q;
  logic [DATA_MAX-1:0] shreg, data_aligned;
  logic                fe_acc;
  logic                pe_calc;
  logic                last_bit;
  logic                par_next;

  assign last_bit     = (cnt == chsz_q - CNT_W'(1));
  assign shamt        = CNT_W'(DATA_MAX) - chsz_q;
  assign data_aligned = shreg >> shamt;

`ifdef USART_RX_PARITY_EN
  logic par_en_q;
  logic par_acc;

  assign par_next = par_en_q;
  assign pe_calc  = par_en_q & par_acc;
`else
  logic unused_upm;

  assign unused_upm = ^upm;
  assign par_next   = 1'b0;
  assign pe_calc    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && !rxd) state_nxt = DATA;
      DATA:    if (en && last_bit) state_nxt = par_next ? PAR : STOP1;
      PAR:     if (en) state_nxt = STOP1;
      STOP1:   if (en) state_nxt = sbs_q ? STOP2 : DONE;
      STOP2:   if (en) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    start    = (state == IDLE) && en && !rxd;
    shift_en = (state == DATA) && en;
    par_smp  = (state == PAR) && en;
    stop_smp = ((state == STOP1) || (state == STOP2)) && en;
    done     = (state == DONE);
  end

  // Frame configuration is captured at the start bit so mid-frame register writes cannot corrupt it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      chsz_q <= '0;
      sbs_q  <= 1'b0;
      shreg  <= '0;
      fe_acc <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      chsz_q <= CNT_W'(chsz_clamp(chsz, 4'(DATA_MAX)));
      sbs_q  <= sbs;
      shreg  <= '0;
      fe_acc <= 1'b0;
    end else if (shift_en) begin
      cnt   <= cnt + CNT_W'(1);
      shreg <= {rxd, shreg[DATA_MAX-1:1]};
    end else if (stop_smp && !rxd) begin
      fe_acc <= 1'b1;
    end
  end

`ifdef USART_RX_PARITY_EN
  // Running XOR seeded with upm[0]; a nonzero result after the parity bit is a parity error.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en_q <= 1'b0;
      par_acc  <= 1'b0;
    end else if (start) begin
      par_en_q <= upm[1];
      par_acc  <= upm[0];
    end else if (shift_en || par_smp) begin
      par_acc  <= par_acc ^ rxd;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o   <= '0;
      rx_valid <= 1'b0;
      fe       <= 1'b0;
      pe       <= 1'b0;
      dor      <= 1'b0;
    end else if (done) begin
      if (!rx_valid || rx_ack) begin
        data_o   <= data_aligned;
        fe       <= fe_acc;
        pe       <= pe_calc;
        rx_valid <= 1'b1;
        if (rx_ack) dor <= 1'b0;
      end else begin
        dor <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
      dor      <= 1'b0;
    end
  end

endmodule
